if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//  Instruction-fetch stage; producer side of the IF/ID pipeline register. Owns the PC, runs a req/ack
//  handshake to instruction memory, predicts taken branches via a small BTB, and presents
//  Instruction / nextPC / hit (+ fetch_valid) to IF/ID. Honours hazard-unit stall and EX-stage redirect.
// PARAMETERS
//  RESET_PC     32'h0000_0000  PC loaded on reset
//  BTB_ENTRIES  16             direct-mapped BTB depth, power of 2, >=2
// PORTS
//  clk            in   1   rising-edge clock
//  rst_n          in   1   synchronous reset, active-low
//  imem_req       out  1   fetch request; held until imem_ack
//  imem_addr      out  32  fetch address (word aligned); stable while imem_req=1
//  imem_ack       in   1   rdata valid this cycle; ignored unless imem_req=1
//  imem_rdata     in   32  fetched instruction word
//  stall          in   1   IF/ID must not advance; hold presented outputs
//  redirect       in   1   mispredict/jump from EX; highest priority
//  redirect_pc    in   32  corrected PC
//  btb_upd        in   1   write BTB entry (resolved taken branch)
//  btb_upd_pc     in   32  branch PC
//  btb_upd_tgt    in   32  branch target
//  Instruction    out  32  fetched instruction to IF/ID
//  nextPC         out  32  fetched PC + 4
//  hit            out  1   BTB hit for this instruction (predicted taken)
//  fetch_valid    out  1   Instruction/nextPC/hit valid this cycle
// BEHAVIOUR
//  Reset (rst_n=0 at edge): pc=RESET_PC, state=REQ, Instruction=32'h0 (NOP), nextPC=0, hit=0,
//   fetch_valid=0, imem_req=0, all BTB valid bits cleared. Reset mid-handshake abandons it; first
//   request after reset goes to RESET_PC one cycle after rst_n rises.
//  FSM: REQ -> WAIT (assert imem_req, imem_addr=pc) ; WAIT --ack,!stall--> REQ (deliver) ;
//   WAIT --ack,stall--> HOLD (buffer word) ; HOLD --!stall--> REQ (deliver buffered) ;
//   WAIT --redirect, no ack--> DROP ; DROP --ack--> REQ (discard word).
//  Deliver: registered; fetch_valid=1 for exactly one cycle, Instruction=word, nextPC=pc+4 (mod 2^32,
//   wrap 32'hFFFF_FFFC -> 0), hit=BTB hit on pc. Latency: ack edge -> outputs valid next cycle.
//  PC update at deliver: pc <= hit ? btb_target : pc+4. Next request issues the cycle after deliver.
//  stall=1: Instruction/nextPC/hit hold, fetch_valid=0, no new request issued; in-flight request
//   still completes (into HOLD).
//  redirect=1 (any state): pc <= redirect_pc, fetch_valid=0, HOLD contents discarded; redirect and
//   ack same cycle -> word discarded, next state REQ. Redirect beats stall.
//  BTB: index pc[IDX+1:2], IDX=log2(BTB_ENTRIES); tag pc[31:IDX+2]; hit = valid & tag match.
//   btb_upd writes at edge; same-cycle lookup of same index sees pre-update contents.
//  imem_addr[1:0] always 2'b00; redirect_pc[1:0] ignored.
// CONFIGURATION
//  IFU_BTB_EN defined: BTB built, prediction as above.
//  IFU_BTB_EN undefined: no BTB storage; hit tied 0; pc advances by +4 only; btb_upd* ignored.
// STRUCTURE
//  Package if_pkg: RESET_PC default, NOP_INSTR=32'h0, FSM state typedef/encoding (REQ,WAIT,HOLD,DROP),
//   PC_W=32, helper for BTB index/tag widths.
//  Sub-module if_btb (lookup + update, valid/tag/target arrays), instantiated only under IFU_BTB_EN.
// TESTING
//  1 Reset: rst_n=0 2 cycles -> outputs 0, imem_req=0; release -> imem_req=1, imem_addr=0x0.
//  2 Stream, ack 1 cycle after req, words A,B,C -> addr 0,4,8; nextPC 4,8,12; fetch_valid pulses.
//  3 stall=1 over ack of word at 0x4 for 3 cycles -> no pulse, outputs held; stall=0 -> word
//    delivered, nextPC=0x8, next addr=0x8.
//  4 redirect to 0x100 while WAIT at 0x8 -> stale ack discarded, next addr=0x100, nextPC later 0x104.
//  5 btb_upd pc=0x10 tgt=0x40, then fetch 0x10 -> hit=1, nextPC=0x14, next addr=0x40
//    (IFU_BTB_EN off: hit=0, next addr=0x14).
//  6 rst_n=0 mid-WAIT, late ack arrives after reset -> ignored; first addr=RESET_PC.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package if_pkg;

    localparam int          PC_W        = 32;
    localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;

    // REQ: idle, next request not yet issued
    // WAIT: request outstanding, waiting for imem_ack
    // HOLD: word fetched while stalled, parked until IF/ID can take it
    // DROP: request outstanding but made stale by a redirect; its word is thrown away
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } if_state_t;

    // Number of PC bits used to index a direct-mapped BTB of the given depth.
    function automatic int btb_idx_w(input int entries);
        return $clog2(entries);
    endfunction

    // Tag covers every word-address bit above the index.
    function automatic int btb_tag_w(input int entries);
        return PC_W - 2 - btb_idx_w(entries);
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between fetch and imem.
// Latency: n/a (signal bundle only).
// Backpressure: imem_req is held with a stable address until imem_ack.
interface if_fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/if_btb.sv
// Direct-mapped branch target buffer: combinational lookup, registered update.
// Latency: lookup same cycle; an update is visible from the cycle after its edge.
// Backpressure: none; an update is accepted every cycle it is presented.
module if_btb
    import if_pkg::*;
#(
    parameter int BTB_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [29:0] lookup_pc_w,
    output logic        lookup_hit,
    output logic [29:0] lookup_tgt_w,
    input  logic        upd,
    input  logic [29:0] upd_pc_w,
    input  logic [29:0] upd_tgt_w
);

    localparam int IDX_W = btb_idx_w(BTB_ENTRIES);
    localparam int TAG_W = btb_tag_w(BTB_ENTRIES);

    logic             valid_q [BTB_ENTRIES];
    logic [TAG_W-1:0] tag_q   [BTB_ENTRIES];
    logic [29:0]      tgt_q   [BTB_ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;

    assign lk_idx = lookup_pc_w[IDX_W-1:0];
    assign lk_tag = lookup_pc_w[29:IDX_W];
    assign up_idx = upd_pc_w[IDX_W-1:0];
    assign up_tag = upd_pc_w[29:IDX_W];

    // Lookup reads the arrays directly, so a same-cycle update is not yet visible.
    always_comb begin
        lookup_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        lookup_tgt_w = tgt_q[lk_idx];
    end

    // Valid bits: cleared on reset, set by a resolved taken branch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else if (upd) begin
            valid_q[up_idx] <= 1'b1;
        end
    end

    // Tag/target payload needs no reset; it is qualified by the valid bit.
    always_ff @(posedge clk) begin
        if (upd) begin
            tag_q[up_idx] <= up_tag;
            tgt_q[up_idx] <= upd_tgt_w;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the PC, fetches over imem req/ack, predicts taken branches (BTB when IFU_BTB_EN is defined).
// Latency: imem_ack edge -> Instruction/nextPC/hit with a one-cycle fetch_valid pulse on the next cycle.
// Backpressure: stall holds outputs and blocks new requests; an in-flight word is parked in HOLD.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = IF_RESET_PC,
    parameter int          BTB_ENTRIES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    if_fetch_unit_if.master   imem,
    input  logic              stall,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    input  logic              btb_upd,
    input  logic [31:0]       btb_upd_pc,
    input  logic [31:0]       btb_upd_tgt,
    output logic [31:0]       Instruction,
    output logic [31:0]       nextPC,
    output logic              hit,
    output logic              fetch_valid
);

    if_state_t   state_q;
    if_state_t   state_d;

    logic [31:0] pc_q;          // address of the next fetch to issue
    logic [31:0] addr_q;        // address of the outstanding / just-fetched word
    logic [31:0] hold_q;        // word parked while IF/ID is stalled
    logic [31:0] instr_q;
    logic [31:0] next_pc_q;
    logic        hit_q;
    logic        fetch_valid_q;

    logic        issue;
    logic        capture;
    logic        deliver;
    logic [31:0] deliver_word;

    logic [31:0] seq_pc;
    logic        pred_hit;
    logic [31:0] pred_tgt;

    logic        unused_bits;

    assign seq_pc = addr_q + 32'd4;

`ifdef IFU_BTB_EN
    logic [29:0] pred_tgt_w;

    if_btb #(
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk          (clk),
        .rst_n        (rst_n),
        .lookup_pc_w  (addr_q[31:2]),
        .lookup_hit   (pred_hit),
        .lookup_tgt_w (pred_tgt_w),
        .upd          (btb_upd),
        .upd_pc_w     (btb_upd_pc[31:2]),
        .upd_tgt_w    (btb_upd_tgt[31:2])
    );

    assign pred_tgt    = {pred_tgt_w, 2'b00};
    assign unused_bits = ^{redirect_pc[1:0], btb_upd_pc[1:0], btb_upd_tgt[1:0]};
`else
    logic unused_cfg;

    // Without a BTB every fetch falls through sequentially.
    assign pred_hit    = 1'b0;
    assign pred_tgt    = seq_pc;
    assign unused_bits = ^{redirect_pc[1:0], btb_upd, btb_upd_pc, btb_upd_tgt};
    assign unused_cfg  = (BTB_ENTRIES < 2);
`endif

    // The request stays up through DROP so the memory can retire the stale access.
    assign imem.imem_req  = (state_q == S_WAIT) || (state_q == S_DROP);
    assign imem.imem_addr = {addr_q[31:2], 2'b00};

    assign Instruction = instr_q;
    assign nextPC      = next_pc_q;
    assign hit         = hit_q;
    assign fetch_valid = fetch_valid_q;

    // Next-state and per-cycle actions; redirect outranks stall and ack.
    always_comb begin
        state_d      = state_q;
        issue        = 1'b0;
        capture      = 1'b0;
        deliver      = 1'b0;
        deliver_word = hold_q;
        unique case (state_q)
            S_REQ: begin
                if (!redirect && !stall) begin
                    state_d = S_WAIT;
                    issue   = 1'b1;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    state_d = imem.imem_ack ? S_REQ : S_DROP;
                end else if (imem.imem_ack) begin
                    if (stall) begin
                        state_d = S_HOLD;
                        capture = 1'b1;
                    end else begin
                        state_d      = S_REQ;
                        deliver      = 1'b1;
                        deliver_word = imem.imem_rdata;
                    end
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    state_d = S_REQ;
                end else if (!stall) begin
                    state_d = S_REQ;
                    deliver = 1'b1;
                end
            end
            S_DROP: begin
                if (imem.imem_ack) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    // FSM state register; reset abandons any outstanding request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // PC, fetch address and hold buffer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q   <= {RESET_PC[31:2], 2'b00};
            addr_q <= {RESET_PC[31:2], 2'b00};
            hold_q <= NOP_INSTR;
        end else begin
            if (redirect) begin
                pc_q <= {redirect_pc[31:2], 2'b00};
            end else if (deliver) begin
                pc_q <= pred_hit ? pred_tgt : seq_pc;
            end
            if (issue) begin
                addr_q <= pc_q;
            end
            if (capture) begin
                hold_q <= imem.imem_rdata;
            end
        end
    end

    // IF/ID-facing outputs: load on deliver, otherwise hold with fetch_valid low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr_q       <= NOP_INSTR;
            next_pc_q     <= 32'h0;
            hit_q         <= 1'b0;
            fetch_valid_q <= 1'b0;
        end else begin
            fetch_valid_q <= deliver;
            if (deliver) begin
                instr_q   <= deliver_word;
                next_pc_q <= seq_pc;
                hit_q     <= pred_hit;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed self-checking bench for if_fetch_unit.
// Latency: outputs sampled 1ns after each rising edge.
// Backpressure: the bench plays imem and the hazard unit, driving ack/stall/redirect by hand.
module tb_if_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        btb_upd;
    logic [31:0] btb_upd_pc;
    logic [31:0] btb_upd_tgt;
    logic [31:0] Instruction;
    logic [31:0] nextPC;
    logic        hit;
    logic        fetch_valid;

    int n_checks;
    int n_fail;

    if_fetch_unit_if imem_bus ();

    if_fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem        (imem_bus),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .btb_upd     (btb_upd),
        .btb_upd_pc  (btb_upd_pc),
        .btb_upd_tgt (btb_upd_tgt),
        .Instruction (Instruction),
        .nextPC      (nextPC),
        .hit         (hit),
        .fetch_valid (fetch_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Return the outstanding word in the cycle after the current one.
    task automatic ack_word(input logic [31:0] word);
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = word;
        tick();
        imem_bus.imem_ack   = 1'b0;
        imem_bus.imem_rdata = 32'h0;
    endtask

    // Expect a delivered word; then step into the next request and check its address.
    task automatic deliver_and_next(input string tag, input logic [31:0] word,
                                    input logic [31:0] exp_npc, input logic [31:0] exp_next_addr);
        ack_word(word);
        chk({tag, "_valid"}, {31'h0, fetch_valid}, 32'h1);
        chk({tag, "_instr"}, Instruction, word);
        chk({tag, "_npc"}, nextPC, exp_npc);
        tick();
        chk({tag, "_pulse"}, {31'h0, fetch_valid}, 32'h0);
        chk({tag, "_req"}, {31'h0, imem_bus.imem_req}, 32'h1);
        chk({tag, "_addr"}, imem_bus.imem_addr, exp_next_addr);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] exp_hit;
        logic [31:0] exp_addr;
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        btb_upd = 1'b0; btb_upd_pc = 32'h0; btb_upd_tgt = 32'h0;
        imem_bus.imem_ack = 1'b0; imem_bus.imem_rdata = 32'h0;

        // 1: reset
        tick();
        tick();
        chk("rst_instr", Instruction, 32'h0);
        chk("rst_npc", nextPC, 32'h0);
        chk("rst_hit", {31'h0, hit}, 32'h0);
        chk("rst_valid", {31'h0, fetch_valid}, 32'h0);
        chk("rst_req", {31'h0, imem_bus.imem_req}, 32'h0);
        rst_n = 1'b1;
        tick();
        chk("rel_req", {31'h0, imem_bus.imem_req}, 32'h1);
        chk("rel_addr", imem_bus.imem_addr, 32'h0);

        // 2: sequential stream
        deliver_and_next("strA", 32'hAAAA_0001, 32'h4, 32'h4);
        deliver_and_next("strB", 32'hBBBB_0002, 32'h8, 32'h8);
        deliver_and_next("strC", 32'hCCCC_0003, 32'hC, 32'hC);

        // 3: stall over an ack (reset first to restart at 0)
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        deliver_and_next("s3A", 32'h1111_0000, 32'h4, 32'h4);
        stall = 1'b1;
        ack_word(32'hDDDD_0004);
        for (int i = 0; i < 3; i++) begin
            chk("stl_valid", {31'h0, fetch_valid}, 32'h0);
            chk("stl_instr", Instruction, 32'h1111_0000);
            chk("stl_npc", nextPC, 32'h4);
            chk("stl_req", {31'h0, imem_bus.imem_req}, 32'h0);
            if (i < 2) tick();
        end
        stall = 1'b0;
        tick();
        chk("unstl_valid", {31'h0, fetch_valid}, 32'h1);
        chk("unstl_instr", Instruction, 32'hDDDD_0004);
        chk("unstl_npc", nextPC, 32'h8);
        tick();
        chk("unstl_addr", imem_bus.imem_addr, 32'h8);

        // 4: redirect while waiting at 0x8; low bits of redirect_pc ignored
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        tick();
        redirect = 1'b0;
        chk("drop_req", {31'h0, imem_bus.imem_req}, 32'h1);
        chk("drop_addr", imem_bus.imem_addr, 32'h8);
        ack_word(32'hBAD0_0008);
        chk("drop_valid", {31'h0, fetch_valid}, 32'h0);
        chk("drop_instr", Instruction, 32'hDDDD_0004);
        tick();
        chk("redir_addr", imem_bus.imem_addr, 32'h100);
        deliver_and_next("redirE", 32'hEEEE_0100, 32'h104, 32'h104);

        // redirect coinciding with ack: word discarded
        redirect = 1'b1; redirect_pc = 32'h200;
        ack_word(32'hBAD0_0104);
        redirect = 1'b0;
        chk("rdack_valid", {31'h0, fetch_valid}, 32'h0);
        tick();
        chk("rdack_addr", imem_bus.imem_addr, 32'h200);
        ack_word(32'h2222_0200);
        chk("rdack_npc", nextPC, 32'h204);

        // 5: BTB update for 0x10 -> 0x40 written alongside a redirect to 0x10
        redirect = 1'b1; redirect_pc = 32'h10;
        btb_upd = 1'b1; btb_upd_pc = 32'h10; btb_upd_tgt = 32'h40;
        tick();
        redirect = 1'b0; btb_upd = 1'b0;
        tick();
        chk("btb_addr", imem_bus.imem_addr, 32'h10);
`ifdef IFU_BTB_EN
        exp_hit = 32'h1; exp_addr = 32'h40;
`else
        exp_hit = 32'h0; exp_addr = 32'h14;
`endif
        ack_word(32'hFFFF_0010);
        chk("btb_hit", {31'h0, hit}, exp_hit);
        chk("btb_npc", nextPC, 32'h14);
        chk("btb_instr", Instruction, 32'hFFFF_0010);
        tick();
        chk("btb_next", imem_bus.imem_addr, exp_addr);

        // PC wrap at the top of the address space
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        ack_word(32'hBAD0_0040);
        tick();
        chk("wrap_addr", imem_bus.imem_addr, 32'hFFFF_FFFC);
        deliver_and_next("wrap", 32'h7777_FFFC, 32'h0, 32'h0);
        chk("wrap_hit", {31'h0, hit}, 32'h0);

        // 6: reset mid-WAIT, late ack after release is ignored
        rst_n = 1'b0;
        tick();
        chk("rst6_req", {31'h0, imem_bus.imem_req}, 32'h0);
        chk("rst6_valid", {31'h0, fetch_valid}, 32'h0);
        rst_n = 1'b1;
        ack_word(32'hBAD0_0000);
        chk("late_valid", {31'h0, fetch_valid}, 32'h0);
        chk("late_req", {31'h0, imem_bus.imem_req}, 32'h1);
        chk("late_addr", imem_bus.imem_addr, 32'h0);
        deliver_and_next("post6", 32'h8888_0000, 32'h4, 32'h4);

        // BTB contents are gone after reset: 0x10 falls through
        redirect = 1'b1; redirect_pc = 32'h10;
        ack_word(32'hBAD0_0004);
        redirect = 1'b0;
        tick();
        chk("clr_addr", imem_bus.imem_addr, 32'h10);
        deliver_and_next("clr", 32'h9999_0010, 32'h14, 32'h14);
        chk("clr_hit", {31'h0, hit}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
